// File: rtl/spi_ram_port_arbiter.sv
// Single-port arbiter for the SPI slave's sample RAM: it serves single-beat host reads and writes,
// runs auto-incrementing sample bursts, and drives the STATUS byte. Everything runs on SCK.
module spi_ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          SCK,
    input  logic          reset,
    input  logic          host_wr_req,
    input  logic          host_rd_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          smp_start,
    input  logic [AW-1:0] smp_base,
    input  logic [AW-1:0] smp_count,
    input  logic [DW-1:0] ext_data,
    output logic          smp_done,
    output logic [7:0]    status,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, HOST_WR, HOST_RD, RD_WAIT, SAMPLE} state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, rem_q, rem_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_base_q, pend_base_d, pend_count_q, pend_count_d;
    logic          busy_q, busy_d, wrap_q, wrap_d, err_q, err_d;
    logic [7:0]    status_q, status_d;
    logic          host_ack_q, host_ack_d, host_rvalid_q, host_rvalid_d, smp_done_q, smp_done_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          start_err;

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        pend_d        = pend_q;
        pend_base_d   = pend_base_q;
        pend_count_d  = pend_count_q;
        busy_d        = busy_q;
        wrap_d        = wrap_q;
        err_d         = err_q;
        host_rdata_d  = host_rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        host_ack_d    = 1'b0;
        host_rvalid_d = 1'b0;
        smp_done_d    = 1'b0;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;

        start_err = smp_start && (busy_q || pend_q);
        if (smp_start && !busy_q && !pend_q) begin
            pend_d       = 1'b1;
            pend_base_d  = smp_base;
            pend_count_d = smp_count;
        end

        case (state_q)
            IDLE: begin
                if (host_wr_req) begin
                    state_d     = HOST_WR;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                    host_ack_d  = 1'b1;
                end else if (host_rd_req) begin
                    state_d    = HOST_RD;
                    mem_en_d   = 1'b1;
                    mem_addr_d = host_addr;
                end else if (pend_q) begin
                    pend_d = 1'b0;
                    if (pend_count_q == '0) begin
                        smp_done_d = 1'b1;
                    end else begin
                        // The first beat issues on the accept edge so BUSY spans exactly count cycles.
                        state_d     = SAMPLE;
                        busy_d      = 1'b1;
                        err_d       = 1'b0;
                        wrap_d      = (pend_base_q == ADDR_MAX) && (pend_count_q > ONE);
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = pend_base_q;
                        mem_wdata_d = ext_data;
                        ptr_d       = pend_base_q + ONE;
                        rem_d       = pend_count_q - ONE;
                    end
                end
            end
            HOST_WR: state_d = IDLE;
            HOST_RD: state_d = RD_WAIT;
            RD_WAIT: begin
                state_d       = IDLE;
                host_rdata_d  = mem_rdata;
                host_rvalid_d = 1'b1;
                host_ack_d    = 1'b1;
            end
            SAMPLE: begin
                if (rem_q != '0) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = ext_data;
                    ptr_d       = ptr_q + ONE;
                    rem_d       = rem_q - ONE;
                    if ((ptr_q == ADDR_MAX) && (rem_q > ONE)) wrap_d = 1'b1;
                end else begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    smp_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A rejected start must stay visible even on the edge that clears ERR for a new burst.
        if (start_err) err_d = 1'b1;
        status_d = {4'b0000, err_d, wrap_d, busy_d, !busy_d};
    end

    always_ff @(posedge SCK) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            rem_q         <= '0;
            pend_q        <= 1'b0;
            pend_base_q   <= '0;
            pend_count_q  <= '0;
            busy_q        <= 1'b0;
            wrap_q        <= 1'b0;
            err_q         <= 1'b0;
            status_q      <= 8'h01;
            host_ack_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            smp_done_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so all flops sample pre-edge values together.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            pend_q        <= pend_d;
            pend_base_q   <= pend_base_d;
            pend_count_q  <= pend_count_d;
            busy_q        <= busy_d;
            wrap_q        <= wrap_d;
            err_q         <= err_d;
            status_q      <= status_d;
            host_ack_q    <= host_ack_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            smp_done_q    <= smp_done_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign host_ack    = host_ack_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign smp_done    = smp_done_q;
    assign status      = status_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_spi_ram_port_arbiter.sv
// Directed bench for spi_ram_port_arbiter: host beats, sample bursts, wrap/error flags,
// arbitration against bursts and reset in the middle of a burst, with a behavioural RAM.
module tb_spi_ram_port_arbiter;

    logic       SCK = 1'b0;
    logic       reset;
    logic       host_wr_req, host_rd_req;
    logic [7:0] host_addr, host_wdata;
    logic       host_ack, host_rvalid;
    logic [7:0] host_rdata;
    logic       smp_start;
    logic [7:0] smp_base, smp_count, ext_data;
    logic       smp_done;
    logic [7:0] status;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] ram [256];
    logic [7:0] data_tbl [4];
    logic [7:0] addr_tbl [4];
    logic [7:0] stat_tbl [4];

    int vectors = 0;
    int fails   = 0;

    spi_ram_port_arbiter #(.AW(8), .DW(8)) dut (
        .SCK(SCK), .reset(reset),
        .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .smp_start(smp_start), .smp_base(smp_base), .smp_count(smp_count),
        .ext_data(ext_data), .smp_done(smp_done), .status(status),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 SCK = ~SCK;

    // RAM with one-cycle read latency.
    always @(posedge SCK) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge SCK);
        @(negedge SCK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [7:0] addr, input logic [7:0] data,
                              input logic [7:0] stat);
        check({tag, " mem_en"},    {31'd0, mem_en}, 32'd1);
        check({tag, " mem_we"},    {31'd0, mem_we}, 32'd1);
        check({tag, " mem_addr"},  {24'd0, mem_addr}, {24'd0, addr});
        check({tag, " mem_wdata"}, {24'd0, mem_wdata}, {24'd0, data});
        check({tag, " status"},    {24'd0, status}, {24'd0, stat});
        check({tag, " smp_done"},  {31'd0, smp_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        host_wr_req = 1'b0; host_rd_req = 1'b0; host_addr = '0; host_wdata = '0;
        smp_start = 1'b0; smp_base = '0; smp_count = '0; ext_data = '0;
        mem_rdata = '0;
        tick(); tick();
        check("reset status",   {24'd0, status}, 32'h01);
        check("reset host_ack", {31'd0, host_ack}, 32'd0);
        check("reset rvalid",   {31'd0, host_rvalid}, 32'd0);
        check("reset smp_done", {31'd0, smp_done}, 32'd0);
        check("reset mem_en",   {31'd0, mem_en}, 32'd0);
        check("reset mem_we",   {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", {24'd0, mem_addr}, 32'd0);
        reset = 1'b0;

        // Host write 0x10 <= 0xA5.
        host_wr_req = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
        tick();
        check("hw mem_en",   {31'd0, mem_en}, 32'd1);
        check("hw mem_we",   {31'd0, mem_we}, 32'd1);
        check("hw addr",     {24'd0, mem_addr}, 32'h10);
        check("hw wdata",    {24'd0, mem_wdata}, 32'hA5);
        check("hw ack",      {31'd0, host_ack}, 32'd1);
        host_wr_req = 1'b0;
        tick();
        check("hw ack drop", {31'd0, host_ack}, 32'd0);
        check("hw en drop",  {31'd0, mem_en}, 32'd0);

        // Host read 0x10: rvalid two edges after accept.
        host_rd_req = 1'b1;
        tick();
        check("hr mem_en",   {31'd0, mem_en}, 32'd1);
        check("hr mem_we",   {31'd0, mem_we}, 32'd0);
        check("hr addr",     {24'd0, mem_addr}, 32'h10);
        check("hr rvalid0",  {31'd0, host_rvalid}, 32'd0);
        tick();
        check("hr rvalid1",  {31'd0, host_rvalid}, 32'd0);
        check("hr ack1",     {31'd0, host_ack}, 32'd0);
        tick();
        check("hr rvalid",   {31'd0, host_rvalid}, 32'd1);
        check("hr ack",      {31'd0, host_ack}, 32'd1);
        check("hr rdata",    {24'd0, host_rdata}, 32'hA5);
        host_rd_req = 1'b0;
        tick();
        check("hr rvalid end", {31'd0, host_rvalid}, 32'd0);

        // Burst base 0x02 count 4.
        data_tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
        smp_start = 1'b1; smp_base = 8'h02; smp_count = 8'd4; ext_data = data_tbl[0];
        tick();
        smp_start = 1'b0;
        check("b1 pending status", {24'd0, status}, 32'h01);
        check("b1 pending en",     {31'd0, mem_en}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("b1 beat%0d", i), 8'h02 + 8'(i), data_tbl[i], 8'h02);
            ext_data = data_tbl[(i + 1) % 4];
            tick();
        end
        check("b1 done",   {31'd0, smp_done}, 32'd1);
        check("b1 en off", {31'd0, mem_en}, 32'd0);
        check("b1 status", {24'd0, status}, 32'h01);
        tick();
        check("b1 done pulse", {31'd0, smp_done}, 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("b1 ram%0d", i), {24'd0, ram[8'h02 + 8'(i)]}, {24'd0, data_tbl[i]});

        // Wrapping burst base 0xFE count 4.
        data_tbl = '{8'h01, 8'h02, 8'h03, 8'h04};
        addr_tbl = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        stat_tbl = '{8'h02, 8'h06, 8'h06, 8'h06};
        smp_start = 1'b1; smp_base = 8'hFE; smp_count = 8'd4; ext_data = data_tbl[0];
        tick();
        smp_start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("b2 beat%0d", i), addr_tbl[i], data_tbl[i], stat_tbl[i]);
            ext_data = data_tbl[(i + 1) % 4];
            tick();
        end
        check("b2 done",   {31'd0, smp_done}, 32'd1);
        check("b2 status", {24'd0, status}, 32'h05);
        check("b2 ram00",  {24'd0, ram[8'h00]}, 32'h03);
        tick();

        // Burst 0x30 x3: clears WRAP; host read and second start arrive while busy.
        smp_start = 1'b1; smp_base = 8'h30; smp_count = 8'd3; ext_data = 8'h77;
        tick();
        smp_start = 1'b0;
        check("b3 pend status", {24'd0, status}, 32'h05);
        tick();
        check_beat("b3 beat0", 8'h30, 8'h77, 8'h02);
        host_rd_req = 1'b1; host_addr = 8'h10;
        smp_start = 1'b1; smp_base = 8'h80; smp_count = 8'd9;
        tick();
        smp_start = 1'b0;
        check_beat("b3 beat1", 8'h31, 8'h77, 8'h0A);
        check("b3 stall ack1", {31'd0, host_ack}, 32'd0);
        tick();
        check_beat("b3 beat2", 8'h32, 8'h77, 8'h0A);
        check("b3 stall ack2", {31'd0, host_ack}, 32'd0);
        tick();
        check("b3 done",      {31'd0, smp_done}, 32'd1);
        check("b3 status",    {24'd0, status}, 32'h09);
        check("b3 stall ack3", {31'd0, host_ack}, 32'd0);
        check("b3 en off",    {31'd0, mem_en}, 32'd0);
        tick();
        check("b3 rd en",   {31'd0, mem_en}, 32'd1);
        check("b3 rd we",   {31'd0, mem_we}, 32'd0);
        check("b3 rd addr", {24'd0, mem_addr}, 32'h10);
        tick();
        tick();
        check("b3 rvalid", {31'd0, host_rvalid}, 32'd1);
        check("b3 rdata",  {24'd0, host_rdata}, 32'hA5);
        host_rd_req = 1'b0;
        tick();
        check("b3 no restart", {31'd0, mem_en}, 32'd0);

        // Zero-count start: done next cycle, no writes, ERR kept.
        smp_start = 1'b1; smp_base = 8'h40; smp_count = 8'd0;
        tick();
        smp_start = 1'b0;
        tick();
        check("z done",   {31'd0, smp_done}, 32'd1);
        check("z en",     {31'd0, mem_en}, 32'd0);
        check("z status", {24'd0, status}, 32'h09);
        tick();
        check("z done pulse", {31'd0, smp_done}, 32'd0);

        // Same-cycle host write and start: write first, then burst; reset mid-burst.
        host_wr_req = 1'b1; host_addr = 8'h50; host_wdata = 8'h5A;
        smp_start = 1'b1; smp_base = 8'h60; smp_count = 8'd2; ext_data = 8'hC1;
        tick();
        check("sc wr addr",  {24'd0, mem_addr}, 32'h50);
        check("sc wr data",  {24'd0, mem_wdata}, 32'h5A);
        check("sc wr ack",   {31'd0, host_ack}, 32'd1);
        check("sc wr we",    {31'd0, mem_we}, 32'd1);
        host_wr_req = 1'b0; smp_start = 1'b0;
        tick();
        check("sc gap en", {31'd0, mem_en}, 32'd0);
        tick();
        check_beat("sc beat0", 8'h60, 8'hC1, 8'h02);
        reset = 1'b1; ext_data = 8'hC2;
        tick();
        check("rst en",     {31'd0, mem_en}, 32'd0);
        check("rst status", {24'd0, status}, 32'h01);
        check("rst done",   {31'd0, smp_done}, 32'd0);
        reset = 1'b0;
        tick();
        check("rst idle en1", {31'd0, mem_en}, 32'd0);
        tick();
        check("rst idle en2", {31'd0, mem_en}, 32'd0);
        check("rst idle status", {24'd0, status}, 32'h01);
        check("sc ram50", {24'd0, ram[8'h50]}, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
